// File: rtl/pht_access_scheduler.sv
// pht_access_scheduler
//   Arbitrates a single-port pattern-history table (PHT) of 2-bit saturating
//   counters between decode-stage prediction lookups and EX-stage resolution
//   feedback. Feedback is queued in a small FIFO and applied as a read/modify/
//   write pair. A starvation counter forces pending updates through when
//   lookups monopolise the table. After reset the whole table is swept to
//   weakly-not-taken before any access is allowed.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid, req_pc        prediction request from decode
//   req_ready                lookup granted this cycle (combinational)
//   pred_valid, pred_taken   prediction, one cycle after a grant
//   fb_valid, fb_pc, fb_taken  branch resolution feedback
//   fb_drop                  feedback discarded (FIFO full)
//   tbl_en, tbl_we, tbl_index, tbl_wdata, tbl_rdata   table port (1-cycle read)
//   init_done                table sweep finished
module pht_access_scheduler #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [ADDR_WIDTH-1:0]  req_pc,
  output logic                   req_ready,
  output logic                   pred_valid,
  output logic                   pred_taken,
  input  logic                   fb_valid,
  input  logic [ADDR_WIDTH-1:0]  fb_pc,
  input  logic                   fb_taken,
  output logic                   fb_drop,
  output logic                   tbl_en,
  output logic                   tbl_we,
  output logic [INDEX_WIDTH-1:0] tbl_index,
  output logic [1:0]             tbl_wdata,
  input  logic [1:0]             tbl_rdata,
  output logic                   init_done
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W    = $clog2(STARVE_LIMIT + 1);
  localparam int TBL_SIZE = 2 ** INDEX_WIDTH;

  typedef enum logic [1:0] {INIT, RUN, UPD_WR} state_t;

  state_t                 state, state_next;
  logic [INDEX_WIDTH-1:0] sweep_idx;
  logic [INDEX_WIDTH:0]   fifo_mem [FIFO_DEPTH];  // {index, taken}
  logic [PTR_W-1:0]       head, tail;
  logic [CNT_W-1:0]       count;
  logic [STV_W-1:0]       starve_cnt;
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic                   upd_taken;
  logic                   pred_valid_reg;
  logic                   init_done_reg;

  logic [INDEX_WIDTH-1:0] lookup_idx, fb_idx, head_idx;
  logic                   head_taken;
  logic                   fifo_full, fifo_empty, in_run;
  logic                   grant, pop, push;
  logic [1:0]             sat_val;

  // Only the index bits of the PCs are meaningful here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], req_pc[1:0],
                            fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], fb_pc[1:0]};

  assign lookup_idx = req_pc[INDEX_WIDTH+1:2];
  assign fb_idx     = fb_pc[INDEX_WIDTH+1:2];
  assign head_idx   = fifo_mem[head][INDEX_WIDTH:1];
  assign head_taken = fifo_mem[head][0];

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign in_run     = (state == RUN);

  // Lookups are held off when the FIFO is full so feedback is not lost, and
  // when an update has waited STARVE_LIMIT cycles.
  assign grant = in_run && req_valid && !fifo_full &&
                 (starve_cnt < STV_W'(STARVE_LIMIT));
  assign pop   = in_run && !grant && !fifo_empty;
  // A slot freed by this cycle's pop can be reused immediately.
  assign push  = fb_valid && (!fifo_full || pop);

  assign fb_drop    = fb_valid && !push;
  assign req_ready  = grant;
  assign pred_valid = pred_valid_reg;
  assign pred_taken = pred_valid_reg & tbl_rdata[1];
  assign init_done  = init_done_reg;

  always_comb begin
    sat_val = tbl_rdata;
    if (upd_taken) begin
      if (tbl_rdata != 2'b11) sat_val = tbl_rdata + 2'b01;
    end else begin
      if (tbl_rdata != 2'b00) sat_val = tbl_rdata - 2'b01;
    end
  end

  always_comb begin
    state_next = state;
    tbl_en     = 1'b0;
    tbl_we     = 1'b0;
    tbl_index  = '0;
    tbl_wdata  = 2'b00;
    case (state)
      INIT: begin
        // Outputs stay quiet while reset is held.
        if (!rst) begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_index = sweep_idx;
          tbl_wdata = 2'b01;
        end
        if (sweep_idx == INDEX_WIDTH'(TBL_SIZE - 1)) state_next = RUN;
      end
      RUN: begin
        if (grant) begin
          tbl_en    = 1'b1;
          tbl_index = lookup_idx;
        end else if (pop) begin
          tbl_en     = 1'b1;
          tbl_index  = head_idx;
          state_next = UPD_WR;
        end
      end
      UPD_WR: begin
        tbl_en     = 1'b1;
        tbl_we     = 1'b1;
        tbl_index  = upd_idx;
        tbl_wdata  = sat_val;
        state_next = RUN;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= INIT;
      sweep_idx      <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      starve_cnt     <= '0;
      upd_idx        <= '0;
      upd_taken      <= 1'b0;
      pred_valid_reg <= 1'b0;
      init_done_reg  <= 1'b0;
    end else begin
      state          <= state_next;
      pred_valid_reg <= grant;
      if (state == INIT) begin
        sweep_idx <= sweep_idx + 1'b1;
        if (state_next == RUN) init_done_reg <= 1'b1;
      end
      if (in_run) begin
        if (pop || fifo_empty) starve_cnt <= '0;
        else if (starve_cnt < STV_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
      end
      if (pop) begin
        upd_idx   <= head_idx;
        upd_taken <= head_taken;
        head      <= (head == PTR_W'(FIFO_DEPTH - 1)) ? '0 : head + 1'b1;
      end
      if (push) tail <= (tail == PTR_W'(FIFO_DEPTH - 1)) ? '0 : tail + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= {fb_idx, fb_taken};
  end

endmodule

// File: tb/tb_pht_access_scheduler.sv
module tb_pht_access_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        fb_valid;
  logic [31:0] fb_pc;
  logic        fb_taken;
  logic        fb_drop;
  logic        tbl_en;
  logic        tbl_we;
  logic [5:0]  tbl_index;
  logic [1:0]  tbl_wdata;
  logic [1:0]  tbl_rdata;
  logic        init_done;

  int errors = 0;
  int checks = 0;

  logic       exp_pred_q[$];
  logic [7:0] exp_wr_q[$];  // {index, wdata}

  always #5 clk = ~clk;

  pht_access_scheduler #(
    .ADDR_WIDTH(32), .INDEX_WIDTH(6), .FIFO_DEPTH(4), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_taken(fb_taken), .fb_drop(fb_drop),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_index(tbl_index),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata), .init_done(init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares predictions and post-init table writes against the
  // queues filled by the stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      if (pred_valid) begin
        if (exp_pred_q.size() == 0) chk("pred_unexpected", 1, 0);
        else begin
          logic e;
          e = exp_pred_q.pop_front();
          chk("pred_taken", {31'd0, pred_taken}, {31'd0, e});
          $display("pred: taken=%0d expected=%0d", pred_taken, e);
        end
      end
      if (tbl_we && init_done) begin
        if (exp_wr_q.size() == 0) chk("write_unexpected", {24'd0, tbl_index, tbl_wdata}, 0);
        else begin
          logic [7:0] e;
          e = exp_wr_q.pop_front();
          chk("upd_write", {24'd0, tbl_index, tbl_wdata}, {24'd0, e});
          $display("write: idx=%0d wdata=%0d expected idx=%0d wdata=%0d",
                   tbl_index, tbl_wdata, e[7:2], e[1:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tbl_en"}, {31'd0, tbl_en}, 0);
    chk({tag, "_tbl_we"}, {31'd0, tbl_we}, 0);
    chk({tag, "_tbl_index"}, {26'd0, tbl_index}, 0);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 0);
    chk({tag, "_pred_valid"}, {31'd0, pred_valid}, 0);
    chk({tag, "_pred_taken"}, {31'd0, pred_taken}, 0);
    chk({tag, "_fb_drop"}, {31'd0, fb_drop}, 0);
    chk({tag, "_init_done"}, {31'd0, init_done}, 0);
  endtask

  // Drain of the four feedback entries queued during init.
  logic [5:0] drain_idx [4] = '{6'd2, 6'd3, 6'd4, 6'd5};
  logic [1:0] drain_rd  [4] = '{2'b11, 2'b00, 2'b01, 2'b10};

  // Starvation scenario, one row per cycle.
  logic       st_rv  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  logic       st_rdy [9] = '{0, 1, 1, 1, 1, 0, 0, 1, 0};
  logic [1:0] st_rd  [9] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};

  initial begin
    rst = 1'b1; req_valid = 0; req_pc = 0; fb_valid = 0; fb_pc = 0; fb_taken = 0;
    tbl_rdata = 2'b00;

    // Reset state
    @(negedge clk);
    check_idle_outputs("reset");
    $display("reset: tbl_en=%0d init_done=%0d", tbl_en, init_done);
    next_cycle();
    rst = 1'b0;

    // Init sweep, with lookups attempted and five feedbacks queued
    for (int k = 0; k < 64; k++) begin
      req_valid = (k < 60);
      req_pc    = 32'h40;
      fb_valid  = (k < 5);
      fb_pc     = 32'h8 + 32'(4 * k);
      fb_taken  = ~k[0];
      @(negedge clk);
      chk("sweep_en", {31'd0, tbl_en}, 1);
      chk("sweep_we", {31'd0, tbl_we}, 1);
      chk("sweep_index", {26'd0, tbl_index}, k);
      chk("sweep_wdata", {30'd0, tbl_wdata}, 1);
      chk("sweep_req_ready", {31'd0, req_ready}, 0);
      chk("sweep_fb_drop", {31'd0, fb_drop}, (k == 4) ? 1 : 0);
      if (k == 63) chk("init_done_early", {31'd0, init_done}, 0);
      $display("sweep: k=%0d idx=%0d wdata=%0d fb_drop=%0d", k, tbl_index, tbl_wdata, fb_drop);
      if (k < 4) exp_wr_q.push_back({drain_idx[k], (k == 0) ? 2'b11 : (k == 1) ? 2'b00 :
                                                   (k == 2) ? 2'b10 : 2'b01});
      next_cycle();
    end
    req_valid = 0; fb_valid = 0;

    // Drain: read/write pairs, no lookups
    for (int d = 0; d < 8; d++) begin
      tbl_rdata = (d % 2 == 1) ? drain_rd[d / 2] : 2'b00;
      @(negedge clk);
      if (d == 0) chk("init_done", {31'd0, init_done}, 1);
      chk("drain_en", {31'd0, tbl_en}, 1);
      chk("drain_we", {31'd0, tbl_we}, (d % 2 == 1) ? 1 : 0);
      chk("drain_index", {26'd0, tbl_index}, {26'd0, drain_idx[d / 2]});
      chk("drain_req_ready", {31'd0, req_ready}, 0);
      $display("drain: d=%0d en=%0d we=%0d idx=%0d", d, tbl_en, tbl_we, tbl_index);
      next_cycle();
    end
    @(negedge clk);
    chk("drained_en", {31'd0, tbl_en}, 0);
    chk("drained_we", {31'd0, tbl_we}, 0);
    next_cycle();

    // Lookups: pc 0x40 -> index 16 (rdata 10), pc 0x44 -> index 17 (rdata 01)
    req_valid = 1; req_pc = 32'h40;
    @(negedge clk);
    chk("lookup_ready", {31'd0, req_ready}, 1);
    chk("lookup_index", {26'd0, tbl_index}, 16);
    chk("lookup_we", {31'd0, tbl_we}, 0);
    exp_pred_q.push_back(1'b1);
    $display("lookup: pc=40 ready=%0d idx=%0d", req_ready, tbl_index);
    next_cycle();
    req_pc = 32'h44; tbl_rdata = 2'b10;
    @(negedge clk);
    chk("lookup2_index", {26'd0, tbl_index}, 17);
    chk("pred_taken_direct", {31'd0, pred_taken}, 1);
    exp_pred_q.push_back(1'b0);
    $display("lookup: pc=44 ready=%0d idx=%0d", req_ready, tbl_index);
    next_cycle();
    req_valid = 0; tbl_rdata = 2'b01;
    @(negedge clk);
    chk("post_lookup_en", {31'd0, tbl_en}, 0);
    next_cycle();

    // Starvation: one pending update (pc 0x20 -> index 8, taken)
    for (int c = 0; c < 9; c++) begin
      req_valid = st_rv[c];
      req_pc    = 32'h100 + 32'(4 * c);
      fb_valid  = (c == 0);
      fb_pc     = 32'h20;
      fb_taken  = 1'b1;
      tbl_rdata = st_rd[c];
      if (c == 0) exp_wr_q.push_back({6'd8, 2'b11});
      @(negedge clk);
      chk("starve_ready", {31'd0, req_ready}, {31'd0, st_rdy[c]});
      if (st_rdy[c]) begin
        chk("starve_lookup_idx", {26'd0, tbl_index}, c);
        exp_pred_q.push_back(st_rd[c + 1][1]);
      end
      if (c == 5) begin
        chk("starve_read_en", {31'd0, tbl_en}, 1);
        chk("starve_read_we", {31'd0, tbl_we}, 0);
        chk("starve_read_idx", {26'd0, tbl_index}, 8);
      end
      if (c == 6) chk("starve_upd_we", {31'd0, tbl_we}, 1);
      $display("starve: c=%0d ready=%0d en=%0d we=%0d idx=%0d", c, req_ready, tbl_en, tbl_we, tbl_index);
      next_cycle();
    end
    req_valid = 0; fb_valid = 0; tbl_rdata = 2'b00;

    // Reset during UPD_WR with another entry pending
    fb_valid = 1; fb_pc = 32'h30; fb_taken = 0;
    @(negedge clk);
    chk("pre_rst_idle", {31'd0, tbl_en}, 0);
    next_cycle();
    fb_pc = 32'h34;
    @(negedge clk);
    chk("pre_rst_read_idx", {26'd0, tbl_index}, 12);
    chk("pre_rst_read_en", {31'd0, tbl_en}, 1);
    next_cycle();
    fb_valid = 0;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    $display("mid-update reset: tbl_we=%0d tbl_en=%0d", tbl_we, tbl_en);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("resweep_index", {26'd0, tbl_index}, k);
      chk("resweep_we", {31'd0, tbl_we}, 1);
      if (k == 0) $display("resweep: first idx=%0d", tbl_index);
      next_cycle();
    end
    @(negedge clk);
    chk("reinit_done", {31'd0, init_done}, 1);
    chk("flushed_en", {31'd0, tbl_en}, 0);
    $display("reinit: init_done=%0d tbl_en=%0d", init_done, tbl_en);
    next_cycle();
    @(negedge clk);
    chk("flushed_en2", {31'd0, tbl_en}, 0);
    next_cycle();

    chk("pred_queue_empty", exp_pred_q.size(), 0);
    chk("write_queue_empty", exp_wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pht_access_scheduler.md
PHT_ACCESS_SCHEDULER -- requirements
Module: pht_access_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC width.
REQ-002 SHALL have parameter INDEX_WIDTH, default 6, pattern-history-table (PHT) index width; table holds 2**INDEX_WIDTH 2-bit counters.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of pending feedback-update entries.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, number of consecutive cycles an update may be denied before it is forced.
REQ-005 SHALL have port clk, in, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, in, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid, in, 1, decode requests a prediction.
REQ-008 SHALL have port req_pc, in, ADDR_WIDTH, PC of the branch being predicted.
REQ-009 SHALL have port req_ready, out, 1, lookup granted this cycle (combinational).
REQ-010 SHALL have port pred_valid, out, 1, prediction available; asserted exactly 1 cycle after a grant.
REQ-011 SHALL have port pred_taken, out, 1, 1 = TAKEN; equals tbl_rdata[1] when pred_valid=1, else 0.
REQ-012 SHALL have port fb_valid, in, 1, EX branch-resolution feedback.
REQ-013 SHALL have port fb_pc, in, ADDR_WIDTH, PC of the resolved branch.
REQ-014 SHALL have port fb_taken, in, 1, actual outcome, 1 = TAKEN.
REQ-015 SHALL have port fb_drop, out, 1, one-cycle pulse: feedback discarded because the FIFO was full.
REQ-016 SHALL have table ports tbl_en (out, 1), tbl_we (out, 1), tbl_index (out, INDEX_WIDTH), tbl_wdata (out, 2), and tbl_rdata (in, 2); tbl_rdata is valid 1 cycle after a read.
REQ-017 SHALL have port init_done, out, 1, high once the table sweep completes.

Function
REQ-018 SHALL compute index = pc[INDEX_WIDTH+1:2] for both lookups and feedback.
REQ-019 SHALL implement FSM states INIT, RUN and UPD_WR.
REQ-020 INIT SHALL write 2'b01 (weakly not taken) to indices 0..2**INDEX_WIDTH-1, one per cycle, then enter RUN; init_done SHALL set on the RUN entry edge.
REQ-021 SHALL hold req_ready=0 in INIT and in UPD_WR.
REQ-022 In RUN, lookup SHALL win the table if req_valid=1, the FIFO is not full, and starve_cnt<STARVE_LIMIT; on a win, issue tbl_en=1, tbl_we=0, tbl_index=lookup index, and req_ready=1.
REQ-023 In RUN, if lookup does not win and the FIFO is non-empty, the FIFO head SHALL be read (tbl_en=1, tbl_we=0, pop); the FSM goes to UPD_WR.
REQ-024 UPD_WR SHALL write the popped index with the saturating counter (TAKEN: +1, capped at 3; NOT_TAKEN: -1, floored at 0) applied to tbl_rdata, then return to RUN; total 2 cycles per update.
REQ-025 starve_cnt SHALL increment each RUN cycle in which the FIFO is non-empty and no update read is issued; it SHALL clear when an update read is issued or the FIFO is empty; it saturates at STARVE_LIMIT.
REQ-026 The FIFO SHALL push {index, fb_taken} when fb_valid=1 and (count<FIFO_DEPTH or a pop occurs this cycle); otherwise, with fb_valid=1, fb_drop=1 and the entry is discarded.
REQ-027 The FIFO SHALL accept pushes in every state, including INIT and UPD_WR.
REQ-028 Lookups SHALL read the table as stored; pending FIFO updates are not forwarded.
REQ-029 tbl_en=0 and tbl_we=0 SHALL hold in RUN cycles with no grant and an empty FIFO.

Reset
REQ-030 While rst=1, the block SHALL be in INIT with sweep index 0, FIFO empty, starve_cnt=0, and all outputs 0.
REQ-031 Reset asserted mid-sweep or mid-update SHALL abort the operation and flush the FIFO; the sweep restarts from index 0 after release.

Verification
REQ-032 Reset release: tbl_we=1 with wdata=2'b01 on indices 0..63 for 64 cycles; init_done=1 at cycle 64; req_ready=0 throughout.
REQ-033 After init, req_valid with pc=0x40 and tbl_rdata=2'b10 returns: req_ready=1, tbl_index=16; next cycle pred_valid=1, pred_taken=1.
REQ-034 fb_valid with pc=0x8 and fb_taken=1, no lookups, tbl_rdata=2'b11: read index 2, then write 2'b11 (saturated); for NOT_TAKEN with rdata=2'b00, write 2'b00.
REQ-035 Continuous req_valid with one FIFO entry pending: 4 lookup grants, then cycle 5 req_ready=0 and the update is read, then UPD_WR; lookups resume after.
REQ-036 Five back-to-back fb_valid during INIT: first 4 accepted, 5th gives fb_drop=1; after init, 4 updates drain in 8 cycles.
REQ-037 rst pulse in UPD_WR: no write issued, FIFO empty, and the sweep restarts at index 0.
